// File: rtl/rv64g_pkg.sv
// rv64g_pkg: shared types and constants for the RV64G front end.
//   XLEN             - integer register / address width.
//   DECODE_OUT_DEPTH - entries in the decode-stage output buffer (only 2 is supported).
//   op_class_e       - coarse instruction class produced by the decoder.
//   decoded_instr_t  - decoded command handed from decode to issue.
//   sext32()         - sign-extends a 32-bit immediate to XLEN.
package rv64g_pkg;

  localparam int unsigned XLEN             = 64;
  localparam int unsigned DECODE_OUT_DEPTH = 2;

  typedef enum logic [3:0] {
    OPC_NONE,
    OPC_LUI,
    OPC_AUIPC,
    OPC_JAL,
    OPC_JALR,
    OPC_BRANCH,
    OPC_LOAD,
    OPC_STORE,
    OPC_ALUI,
    OPC_ALU,
    OPC_FENCE,
    OPC_SYSTEM,
    OPC_AMO,
    OPC_FP_LOAD,
    OPC_FP_STORE,
    OPC_FP_OP
  } op_class_e;

  // Register fields are the raw instruction bit-fields; consumers qualify
  // them with op. imm is already sign-extended for the instruction format.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    op_class_e       op;
    logic [2:0]      funct3;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic            word;     // *W variant (OP-32 / OP-IMM-32)
    logic            illegal;  // unrecognised major opcode
  } decoded_instr_t;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

endpackage

// File: rtl/rv64g_instr_decoder.sv
// rv64g_instr_decoder: purely combinational RV64G major-opcode decoder.
//   pc_i   - instruction address, copied into cmd_o.pc.
//   code_i - 32-bit instruction word.
//   cmd_o  - decoded command; unknown or compressed encodings give
//            illegal=1 with every field except pc cleared.
module rv64g_instr_decoder
  import rv64g_pkg::*;
(
  input  logic [XLEN-1:0] pc_i,
  input  logic [31:0]     code_i,
  output decoded_instr_t  cmd_o
);

  logic [6:0]  opcode;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = code_i[6:0];
  assign imm_i  = {{20{code_i[31]}}, code_i[31:20]};
  assign imm_s  = {{20{code_i[31]}}, code_i[31:25], code_i[11:7]};
  assign imm_b  = {{19{code_i[31]}}, code_i[31], code_i[7], code_i[30:25], code_i[11:8], 1'b0};
  assign imm_u  = {code_i[31:12], 12'b0};
  assign imm_j  = {{11{code_i[31]}}, code_i[31], code_i[19:12], code_i[20], code_i[30:21], 1'b0};

  always_comb begin
    cmd_o        = '0;
    cmd_o.pc     = pc_i;
    cmd_o.funct3 = code_i[14:12];
    cmd_o.rd     = code_i[11:7];
    cmd_o.rs1    = code_i[19:15];
    cmd_o.rs2    = code_i[24:20];
    case (opcode)
      7'b0110111: begin cmd_o.op = OPC_LUI;    cmd_o.imm = sext32(imm_u); end
      7'b0010111: begin cmd_o.op = OPC_AUIPC;  cmd_o.imm = sext32(imm_u); end
      7'b1101111: begin cmd_o.op = OPC_JAL;    cmd_o.imm = sext32(imm_j); end
      7'b1100111: begin cmd_o.op = OPC_JALR;   cmd_o.imm = sext32(imm_i); end
      7'b1100011: begin cmd_o.op = OPC_BRANCH; cmd_o.imm = sext32(imm_b); end
      7'b0000011: begin cmd_o.op = OPC_LOAD;   cmd_o.imm = sext32(imm_i); end
      7'b0100011: begin cmd_o.op = OPC_STORE;  cmd_o.imm = sext32(imm_s); end
      7'b0010011: begin cmd_o.op = OPC_ALUI;   cmd_o.imm = sext32(imm_i); end
      7'b0011011: begin cmd_o.op = OPC_ALUI;   cmd_o.imm = sext32(imm_i); cmd_o.word = 1'b1; end
      7'b0110011: cmd_o.op = OPC_ALU;
      7'b0111011: begin cmd_o.op = OPC_ALU;    cmd_o.word = 1'b1; end
      7'b0001111: begin cmd_o.op = OPC_FENCE;  cmd_o.imm = sext32(imm_i); end
      7'b1110011: begin cmd_o.op = OPC_SYSTEM; cmd_o.imm = sext32(imm_i); end
      7'b0101111: cmd_o.op = OPC_AMO;
      7'b0000111: begin cmd_o.op = OPC_FP_LOAD;  cmd_o.imm = sext32(imm_i); end
      7'b0100111: begin cmd_o.op = OPC_FP_STORE; cmd_o.imm = sext32(imm_s); end
      7'b1010011, 7'b1000011, 7'b1000111, 7'b1001011, 7'b1001111: cmd_o.op = OPC_FP_OP;
      default: begin
        cmd_o         = '0;
        cmd_o.pc      = pc_i;
        cmd_o.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/rv64g_decode_ctrl.sv
// rv64g_decode_ctrl: decode-stage sequencer between fetch and issue.
//   clk_i, arst_ni      - clock (rising edge) and asynchronous active-low reset.
//   flush_i             - drop stage register and output buffer contents.
//   fetch_valid_i/_ready_o, pc_i, code_i - instruction input handshake.
//   cmd_o, cmd_valid_o, cmd_ready_i      - decoded command output handshake.
// Optional build macro RV64G_DECODE_CTRL_PERF_EN adds 64-bit counters
//   perf_decoded_o (commands consumed) and perf_stall_o (fetch stalled cycles).
//
// Handshakes: a transfer happens on a rising edge where valid & ready are
// both high. A source holds valid and its payload until that edge. Both ready
// outputs of this block and cmd_valid_o depend on registered state only.
module rv64g_decode_ctrl
  import rv64g_pkg::*;
(
  input  logic            clk_i,
  input  logic            arst_ni,
  input  logic            flush_i,
  input  logic            fetch_valid_i,
  output logic            fetch_ready_o,
  input  logic [XLEN-1:0] pc_i,
  input  logic [31:0]     code_i,
  output decoded_instr_t  cmd_o,
  output logic            cmd_valid_o,
  input  logic            cmd_ready_i
`ifdef RV64G_DECODE_CTRL_PERF_EN
  ,
  output logic [63:0]     perf_decoded_o,
  output logic [63:0]     perf_stall_o
`endif
);

  localparam int unsigned OUT_DEPTH = DECODE_OUT_DEPTH;
  localparam logic [1:0]  FULL_CNT  = 2'(OUT_DEPTH);

  logic            stage_valid_q, stage_valid_d;
  logic [XLEN-1:0] stage_pc_q, stage_pc_d;
  logic [31:0]     stage_code_q, stage_code_d;
  logic [1:0]      count_q, count_d;
  logic            wr_ptr_q, wr_ptr_d;
  logic            rd_ptr_q, rd_ptr_d;
  decoded_instr_t  buf_q [OUT_DEPTH];
  decoded_instr_t  buf_d [OUT_DEPTH];
  decoded_instr_t  dec_cmd;

  logic not_full, in_fire, out_fire, adv;

  rv64g_instr_decoder u_decoder (
    .pc_i   (stage_pc_q),
    .code_i (stage_code_q),
    .cmd_o  (dec_cmd)
  );

  assign not_full      = (count_q < FULL_CNT);
  assign fetch_ready_o = ~stage_valid_q | not_full;
  assign cmd_valid_o   = (count_q != 2'd0);
  assign cmd_o         = cmd_valid_o ? buf_q[rd_ptr_q] : '0;
  assign in_fire       = fetch_valid_i & fetch_ready_o;
  assign out_fire      = cmd_valid_o & cmd_ready_i;
  // Registered count only: a pop in this cycle frees a slot at the next edge.
  assign adv           = stage_valid_q & not_full;

  always_comb begin
    stage_valid_d = stage_valid_q;
    stage_pc_d    = stage_pc_q;
    stage_code_d  = stage_code_q;
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    buf_d         = buf_q;
    if (flush_i) begin
      // Flush wins: same-cycle accept, advance and pop are all discarded.
      stage_valid_d = 1'b0;
      count_d       = 2'd0;
      wr_ptr_d      = 1'b0;
      rd_ptr_d      = 1'b0;
    end else begin
      if (in_fire) begin
        stage_valid_d = 1'b1;
        stage_pc_d    = pc_i;
        stage_code_d  = code_i;
      end else if (adv) begin
        stage_valid_d = 1'b0;
      end
      if (adv) begin
        buf_d[wr_ptr_q] = dec_cmd;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (out_fire) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, adv} - {1'b0, out_fire};
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      stage_valid_q <= 1'b0;
      stage_pc_q    <= '0;
      stage_code_q  <= '0;
      count_q       <= 2'd0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      for (int i = 0; i < OUT_DEPTH; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      stage_valid_q <= stage_valid_d;
      stage_pc_q    <= stage_pc_d;
      stage_code_q  <= stage_code_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      buf_q         <= buf_d;
    end
  end

`ifdef RV64G_DECODE_CTRL_PERF_EN
  // Counters survive flush and wrap naturally at 2^64.
  logic [63:0] perf_decoded_q, perf_decoded_d;
  logic [63:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_decoded_d = perf_decoded_q + {63'd0, out_fire};
    perf_stall_d   = perf_stall_q + {63'd0, fetch_valid_i & ~fetch_ready_o};
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      perf_decoded_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      perf_decoded_q <= perf_decoded_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign perf_decoded_o = perf_decoded_q;
  assign perf_stall_o   = perf_stall_q;
`endif

endmodule

// File: tb/tb_rv64g_decode_ctrl.sv
// tb_rv64g_decode_ctrl: directed testbench for rv64g_decode_ctrl.
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
module tb_rv64g_decode_ctrl;
  import rv64g_pkg::*;

  logic            clk_i;
  logic            arst_ni;
  logic            flush_i;
  logic            fetch_valid_i;
  logic            fetch_ready_o;
  logic [XLEN-1:0] pc_i;
  logic [31:0]     code_i;
  decoded_instr_t  cmd_o;
  logic            cmd_valid_o;
  logic            cmd_ready_i;
`ifdef RV64G_DECODE_CTRL_PERF_EN
  logic [63:0]     perf_decoded_o;
  logic [63:0]     perf_stall_o;
`endif

  int checks;
  int failures;
  logic [XLEN-1:0] exp_q[$];

  rv64g_decode_ctrl dut (
    .clk_i         (clk_i),
    .arst_ni       (arst_ni),
    .flush_i       (flush_i),
    .fetch_valid_i (fetch_valid_i),
    .fetch_ready_o (fetch_ready_o),
    .pc_i          (pc_i),
    .code_i        (code_i),
    .cmd_o         (cmd_o),
    .cmd_valid_o   (cmd_valid_o),
    .cmd_ready_i   (cmd_ready_i)
`ifdef RV64G_DECODE_CTRL_PERF_EN
    ,
    .perf_decoded_o(perf_decoded_o),
    .perf_stall_o  (perf_stall_o)
`endif
  );

  // clock / reset block
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Fetch-side protocol: once offered and not taken, valid must persist.
  logic fetch_pend;
  always @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) fetch_pend <= 1'b0;
    else          fetch_pend <= fetch_valid_i & ~fetch_ready_o;
  end
  always @(negedge clk_i) begin
    if (arst_ni && fetch_pend) begin
      assert (fetch_valid_i) else $error("fetch_valid_i dropped before accept");
    end
  end

  function automatic decoded_instr_t mk(input logic [63:0] pc, input op_class_e op,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [63:0] imm, input logic word,
                                        input logic ill);
    decoded_instr_t d;
    d.pc = pc; d.op = op; d.funct3 = f3; d.rd = rd; d.rs1 = rs1; d.rs2 = rs2;
    d.imm = imm; d.word = word; d.illegal = ill;
    return d;
  endfunction

  // addi x1, x0, 5 (0x0050_0093) at a given pc
  function automatic decoded_instr_t exp_addi5(input logic [63:0] pc);
    return mk(pc, OPC_ALUI, 3'd0, 5'd1, 5'd0, 5'd5, 64'd5, 1'b0, 1'b0);
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    arst_ni = 1'b0; flush_i = 1'b0; fetch_valid_i = 1'b0; cmd_ready_i = 1'b0;
    pc_i = '0; code_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    checks++; if (cmd_valid_o !== 1'b0) begin failures++; $display("FAIL reset_cmd_valid: got %b exp 0", cmd_valid_o); end
    checks++; if (cmd_o !== decoded_instr_t'('0)) begin failures++; $display("FAIL reset_cmd_o: got %h exp 0", cmd_o); end
    checks++; if (fetch_ready_o !== 1'b1) begin failures++; $display("FAIL reset_fetch_ready: got %b exp 1", fetch_ready_o); end
    arst_ni = 1'b1;
    step();
  endtask

  task automatic test_single();
    decoded_instr_t e;
    e = mk(64'h8000_0000, OPC_ALUI, 3'd0, 5'd0, 5'd0, 5'd0, 64'd0, 1'b0, 1'b0);
    fetch_valid_i = 1'b1; pc_i = 64'h8000_0000; code_i = 32'h0000_0013; cmd_ready_i = 1'b1;
    step();
    fetch_valid_i = 1'b0;
    checks++; if (cmd_valid_o !== 1'b0) begin failures++; $display("FAIL single_latency_early: got %b exp 0", cmd_valid_o); end
    step();
    checks++; if (cmd_valid_o !== 1'b1) begin failures++; $display("FAIL single_valid: got %b exp 1", cmd_valid_o); end
    checks++; if (cmd_o !== e) begin failures++; $display("FAIL single_cmd: got %h exp %h", cmd_o, e); end
    step();
    checks++; if (cmd_valid_o !== 1'b0) begin failures++; $display("FAIL single_drain: got %b exp 0", cmd_valid_o); end
  endtask

  task automatic test_decode();
    logic [31:0]    codes [6];
    decoded_instr_t exps  [6];
    logic [63:0]    pc;
    codes[0] = 32'hFFF0_0093; codes[1] = 32'h0011_2223; codes[2] = 32'h1234_52B7;
    codes[3] = 32'h0000_0000; codes[4] = 32'h0010_809B; codes[5] = 32'h0020_8463;
    for (int i = 0; i < 6; i++) begin
      pc = 64'h8000_0040 + 64'(i * 4);
      case (i)
        0: exps[i] = mk(pc, OPC_ALUI,   3'd0, 5'd1, 5'd0, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        1: exps[i] = mk(pc, OPC_STORE,  3'd2, 5'd4, 5'd2, 5'd1,  64'd4, 1'b0, 1'b0);
        2: exps[i] = mk(pc, OPC_LUI,    3'd5, 5'd5, 5'd8, 5'd3,  64'h1234_5000, 1'b0, 1'b0);
        3: exps[i] = mk(pc, OPC_NONE,   3'd0, 5'd0, 5'd0, 5'd0,  64'd0, 1'b0, 1'b1);
        4: exps[i] = mk(pc, OPC_ALUI,   3'd0, 5'd1, 5'd1, 5'd1,  64'd1, 1'b1, 1'b0);
        default: exps[i] = mk(pc, OPC_BRANCH, 3'd0, 5'd8, 5'd1, 5'd2, 64'd8, 1'b0, 1'b0);
      endcase
      fetch_valid_i = 1'b1; pc_i = pc; code_i = codes[i]; cmd_ready_i = 1'b1;
      step();
      fetch_valid_i = 1'b0;
      step();
      checks++;
      if (cmd_valid_o !== 1'b1 || cmd_o !== exps[i]) begin
        failures++; $display("FAIL decode_%0d: got v=%b %h exp v=1 %h", i, cmd_valid_o, cmd_o, exps[i]);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [XLEN-1:0] epc;
    cmd_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) begin
        fetch_valid_i = 1'b1; pc_i = 64'h8000_0000 + 64'(i * 4); code_i = 32'h0050_0093;
        checks++; if (fetch_ready_o !== 1'b1) begin failures++; $display("FAIL b2b_ready_%0d: got %b exp 1", i, fetch_ready_o); end
        exp_q.push_back(pc_i);
      end else begin
        fetch_valid_i = 1'b0;
      end
      step();
      if (i >= 1 && i <= 8) begin
        epc = exp_q.pop_front();
        checks++;
        if (cmd_valid_o !== 1'b1 || cmd_o !== exp_addi5(epc)) begin
          failures++; $display("FAIL b2b_cmd_%0d: got v=%b pc=%h exp v=1 pc=%h", i, cmd_valid_o, cmd_o.pc, epc);
        end
      end else begin
        checks++; if (cmd_valid_o !== 1'b0) begin failures++; $display("FAIL b2b_idle_%0d: got %b exp 0", i, cmd_valid_o); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] base;
    base = 64'h8000_0200;
    cmd_ready_i = 1'b0; code_i = 32'h0050_0093;
    for (int i = 0; i < 3; i++) begin
      fetch_valid_i = 1'b1; pc_i = base + 64'(i * 4);
      step();
    end
    fetch_valid_i = 1'b0;
    checks++; if (dut.count_q !== 2'd2) begin failures++; $display("FAIL bp_count: got %0d exp 2", dut.count_q); end
    checks++; if (dut.stage_valid_q !== 1'b1) begin failures++; $display("FAIL bp_stage_valid: got %b exp 1", dut.stage_valid_q); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (fetch_ready_o !== 1'b0) begin failures++; $display("FAIL bp_ready_low_%0d: got %b exp 0", i, fetch_ready_o); end
      checks++; if (cmd_o !== exp_addi5(base)) begin failures++; $display("FAIL bp_stable_%0d: got pc=%h exp pc=%h", i, cmd_o.pc, base); end
      step();
    end
    cmd_ready_i = 1'b1;
    step();
    checks++; if (fetch_ready_o !== 1'b1) begin failures++; $display("FAIL bp_ready_back: got %b exp 1", fetch_ready_o); end
    for (int i = 1; i < 3; i++) begin
      checks++;
      if (cmd_valid_o !== 1'b1 || cmd_o !== exp_addi5(base + 64'(i * 4))) begin
        failures++; $display("FAIL bp_drain_%0d: got v=%b pc=%h exp pc=%h", i, cmd_valid_o, cmd_o.pc, base + 64'(i * 4));
      end
      step();
    end
    checks++; if (cmd_valid_o !== 1'b0) begin failures++; $display("FAIL bp_empty: got %b exp 0", cmd_valid_o); end
  endtask

  task automatic test_flush();
    cmd_ready_i = 1'b0; code_i = 32'h0050_0093;
    fetch_valid_i = 1'b1; pc_i = 64'h8000_0300; step();
    pc_i = 64'h8000_0304; step();
    fetch_valid_i = 1'b0; step();
    checks++; if (fetch_ready_o !== 1'b1 || cmd_valid_o !== 1'b1) begin failures++; $display("FAIL flush_pre: got rdy=%b v=%b exp 1 1", fetch_ready_o, cmd_valid_o); end
    fetch_valid_i = 1'b1; pc_i = 64'h8000_0100; flush_i = 1'b1;
    step();
    fetch_valid_i = 1'b0; flush_i = 1'b0; cmd_ready_i = 1'b1;
    checks++; if (cmd_valid_o !== 1'b0) begin failures++; $display("FAIL flush_valid: got %b exp 0", cmd_valid_o); end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (cmd_valid_o !== 1'b0) begin failures++; $display("FAIL flush_leak_%0d: got v=%b pc=%h exp v=0", i, cmd_valid_o, cmd_o.pc); end
    end
    // Flush with read/write pointers apart, then check the next command.
    cmd_ready_i = 1'b0;
    fetch_valid_i = 1'b1; pc_i = 64'h8000_0400; step();
    fetch_valid_i = 1'b0; step();
    flush_i = 1'b1; step();
    flush_i = 1'b0;
    checks++; if (cmd_valid_o !== 1'b0) begin failures++; $display("FAIL flush2_valid: got %b exp 0", cmd_valid_o); end
    cmd_ready_i = 1'b1;
    fetch_valid_i = 1'b1; pc_i = 64'h8000_0500; step();
    fetch_valid_i = 1'b0; step();
    checks++; if (cmd_valid_o !== 1'b1 || cmd_o !== exp_addi5(64'h8000_0500)) begin failures++; $display("FAIL flush2_next: got v=%b pc=%h exp v=1 pc=80000500", cmd_valid_o, cmd_o.pc); end
    step();
  endtask

  task automatic test_async_reset();
    decoded_instr_t e;
    cmd_ready_i = 1'b0; code_i = 32'h0050_0093;
    fetch_valid_i = 1'b1; pc_i = 64'h8000_0600; step();
    fetch_valid_i = 1'b0; step();
    checks++; if (cmd_valid_o !== 1'b1) begin failures++; $display("FAIL arst_pre: got %b exp 1", cmd_valid_o); end
    #2 arst_ni = 1'b0;
    #1;
    checks++; if (cmd_valid_o !== 1'b0) begin failures++; $display("FAIL arst_valid: got %b exp 0", cmd_valid_o); end
    checks++; if (cmd_o !== decoded_instr_t'('0)) begin failures++; $display("FAIL arst_cmd: got %h exp 0", cmd_o); end
    checks++; if (fetch_ready_o !== 1'b1) begin failures++; $display("FAIL arst_ready: got %b exp 1", fetch_ready_o); end
    @(posedge clk_i); #1;
    arst_ni = 1'b1;
    e = mk(64'h0000_1000, OPC_ALUI, 3'd0, 5'd0, 5'd0, 5'd0, 64'd0, 1'b0, 1'b0);
    cmd_ready_i = 1'b1;
    fetch_valid_i = 1'b1; pc_i = 64'h0000_1000; code_i = 32'h0000_0013; step();
    fetch_valid_i = 1'b0; step();
    checks++; if (cmd_valid_o !== 1'b1 || cmd_o !== e) begin failures++; $display("FAIL arst_fresh: got v=%b %h exp v=1 %h", cmd_valid_o, cmd_o, e); end
    step();
    checks++; if (cmd_valid_o !== 1'b0) begin failures++; $display("FAIL arst_drain: got %b exp 0", cmd_valid_o); end
  endtask

`ifdef RV64G_DECODE_CTRL_PERF_EN
  task automatic test_perf();
    #2 arst_ni = 1'b0;
    #2 arst_ni = 1'b1;
    cmd_ready_i = 1'b0; fetch_valid_i = 1'b0; code_i = 32'h0050_0093;
    step();
    checks++; if (perf_decoded_o !== 64'd0 || perf_stall_o !== 64'd0) begin failures++; $display("FAIL perf_reset: got %0d %0d exp 0 0", perf_decoded_o, perf_stall_o); end
    for (int i = 0; i < 3; i++) begin
      fetch_valid_i = 1'b1; pc_i = 64'h8000_0700 + 64'(i * 4); step();
    end
    pc_i = 64'h8000_070C;
    step(); step();
    cmd_ready_i = 1'b1;
    step();                               // third stalled cycle, first pop
    step();                               // 0x70C accepted
    fetch_valid_i = 1'b0;
    step(); step(); step();
    fetch_valid_i = 1'b1; pc_i = 64'h8000_0710; step();
    fetch_valid_i = 1'b0; step(); step();
    checks++; if (perf_decoded_o !== 64'd5) begin failures++; $display("FAIL perf_decoded: got %0d exp 5", perf_decoded_o); end
    checks++; if (perf_stall_o !== 64'd3) begin failures++; $display("FAIL perf_stall: got %0d exp 3", perf_stall_o); end
    flush_i = 1'b1; step();
    flush_i = 1'b0; step();
    checks++; if (perf_decoded_o !== 64'd5 || perf_stall_o !== 64'd3) begin failures++; $display("FAIL perf_flush: got %0d %0d exp 5 3", perf_decoded_o, perf_stall_o); end
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_single();
    test_decode();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_async_reset();
`ifdef RV64G_DECODE_CTRL_PERF_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
